// File: rtl/alarm_unit_if.sv
// Bus between the clock core / button front end and the alarm stage.
// The master side supplies time digits, the minute toggle and buttons;
// the slave side (alarm_unit) returns the alarm digits and status.
interface alarm_unit_if;
  logic [3:0] min_u;
  logic [3:0] min_d;
  logic [3:0] hrs_u;
  logic [3:0] hrs_d;
  logic       minute_toggle;
  logic       btn_set_min;
  logic       btn_set_hrs;
  logic       btn_mode;
  logic       btn_snooze;
  logic [3:0] al_min_u;
  logic [3:0] al_min_d;
  logic [3:0] al_hrs_u;
  logic [3:0] al_hrs_d;
  logic       armed;
  logic       ringing;
  logic       buzzer;

  modport master (
    output min_u, min_d, hrs_u, hrs_d, minute_toggle,
    output btn_set_min, btn_set_hrs, btn_mode, btn_snooze,
    input  al_min_u, al_min_d, al_hrs_u, al_hrs_d, armed, ringing, buzzer
  );

  modport slave (
    input  min_u, min_d, hrs_u, hrs_d, minute_toggle,
    input  btn_set_min, btn_set_hrs, btn_mode, btn_snooze,
    output al_min_u, al_min_d, al_hrs_u, al_hrs_d, armed, ringing, buzzer
  );
endinterface

// File: rtl/alarm_unit.sv
// Alarm stage: holds a BCD alarm time, compares it against the clock core a
// fixed settle delay after each minute event, and drives a buzzer square wave
// with snooze, stop and auto-timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------
// DISARMED | alarm off; alarm time may be set
// ARMED    | waiting for a time match; alarm time may be set
// RINGING  | buzzer active; times out after RING_MIN minute events
// SNOOZED  | buzzer silent; re-rings after SNOOZE_MIN minute events
module alarm_unit #(
  parameter int FRECUENCY  = 32768,
  parameter int BUZZ_DIV   = 16,
  parameter int SETTLE     = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 3
) (
  input  logic         clk,
  input  logic         reset,
  alarm_unit_if.slave  bus
);

  if (FRECUENCY < 1 || BUZZ_DIV < 1 || BUZZ_DIV > 65535 ||
      SETTLE < 1 || SETTLE > 15 || SNOOZE_MIN < 1 || SNOOZE_MIN > 15 ||
      RING_MIN < 1 || RING_MIN > 15) begin : g_bad_param
    $error("alarm_unit: parameter out of legal range");
  end

  typedef enum logic [1:0] {DISARMED, ARMED, RINGING, SNOOZED} state_t;

  state_t      state, state_nxt;
  logic        prev_set_min, prev_set_hrs, prev_mode, prev_snooze, prev_toggle;
  logic        set_min_ev, set_hrs_ev, mode_ev, snooze_ev, minute_ev;
  logic [3:0]  al_mu, al_md, al_hu, al_hd;
  logic [3:0]  al_mu_nxt, al_md_nxt, al_hu_nxt, al_hd_nxt;
  logic [3:0]  snooze_cnt, snooze_nxt;
  logic [3:0]  ring_cnt, ring_nxt;
  logic [3:0]  settle_cnt;
  logic [15:0] div_cnt;
  logic        buzzer_q, armed_q, ringing_q;
  logic        set_ok, set_act, cmp_now, time_match;

  assign set_min_ev = bus.btn_set_min & ~prev_set_min;
  assign set_hrs_ev = bus.btn_set_hrs & ~prev_set_hrs;
  assign mode_ev    = bus.btn_mode    & ~prev_mode;
  assign snooze_ev  = bus.btn_snooze  & ~prev_snooze;
  assign minute_ev  = bus.minute_toggle ^ prev_toggle;

  // A fresh minute event restarts the settle window, so it also cancels a
  // comparison that would otherwise land in the same cycle.
  assign cmp_now    = (settle_cnt == 4'd1) && !minute_ev;
  assign time_match = (bus.min_u == al_mu) && (bus.min_d == al_md) &&
                      (bus.hrs_u == al_hu) && (bus.hrs_d == al_hd);

  // Next state, counter updates and alarm-digit increments.
  always_comb begin
    state_nxt  = state;
    snooze_nxt = snooze_cnt;
    ring_nxt   = ring_cnt;
    al_mu_nxt  = al_mu;
    al_md_nxt  = al_md;
    al_hu_nxt  = al_hu;
    al_hd_nxt  = al_hd;
    set_ok     = (state == DISARMED) || (state == ARMED);
    set_act    = set_ok && (set_min_ev || set_hrs_ev);

    if (set_ok && set_min_ev) begin
      if (al_mu == 4'd9) begin
        al_mu_nxt = 4'd0;
        al_md_nxt = (al_md == 4'd5) ? 4'd0 : al_md + 4'd1;
      end else begin
        al_mu_nxt = al_mu + 4'd1;
      end
    end

    if (set_ok && set_hrs_ev) begin
      if (al_hd == 4'd2 && al_hu == 4'd3) begin
        al_hu_nxt = 4'd0;
        al_hd_nxt = 4'd0;
      end else if (al_hu == 4'd9) begin
        al_hu_nxt = 4'd0;
        al_hd_nxt = al_hd + 4'd1;
      end else begin
        al_hu_nxt = al_hu + 4'd1;
      end
    end

    case (state)
      DISARMED: begin
        if (mode_ev) state_nxt = ARMED;
      end
      ARMED: begin
        if (mode_ev) begin
          state_nxt = DISARMED;
        end else if (!set_act && cmp_now && time_match) begin
          state_nxt = RINGING;
          ring_nxt  = 4'd0;
        end
      end
      RINGING: begin
        if (mode_ev) begin
          state_nxt = ARMED;
        end else if (snooze_ev) begin
          state_nxt  = SNOOZED;
          snooze_nxt = 4'(SNOOZE_MIN);
        end else if (minute_ev) begin
          if (ring_cnt == 4'(RING_MIN - 1)) begin
            state_nxt = ARMED;
            ring_nxt  = 4'd0;
          end else begin
            ring_nxt = ring_cnt + 4'd1;
          end
        end
      end
      SNOOZED: begin
        if (mode_ev) begin
          state_nxt = ARMED;
        end else if (minute_ev) begin
          if (snooze_cnt <= 4'd1) begin
            state_nxt  = RINGING;
            snooze_nxt = 4'd0;
            ring_nxt   = 4'd0;
          end else begin
            snooze_nxt = snooze_cnt - 4'd1;
          end
        end
      end
      default: state_nxt = DISARMED;
    endcase
  end

  // State, edge-detect history, counters, buzzer divider and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= DISARMED;
      prev_set_min <= bus.btn_set_min;
      prev_set_hrs <= bus.btn_set_hrs;
      prev_mode    <= bus.btn_mode;
      prev_snooze  <= bus.btn_snooze;
      prev_toggle  <= bus.minute_toggle;
      al_mu        <= 4'd0;
      al_md        <= 4'd0;
      al_hu        <= 4'd0;
      al_hd        <= 4'd0;
      snooze_cnt   <= 4'd0;
      ring_cnt     <= 4'd0;
      settle_cnt   <= 4'd0;
      div_cnt      <= 16'd0;
      buzzer_q     <= 1'b0;
      armed_q      <= 1'b0;
      ringing_q    <= 1'b0;
    end else begin
      state        <= state_nxt;
      prev_set_min <= bus.btn_set_min;
      prev_set_hrs <= bus.btn_set_hrs;
      prev_mode    <= bus.btn_mode;
      prev_snooze  <= bus.btn_snooze;
      prev_toggle  <= bus.minute_toggle;
      al_mu        <= al_mu_nxt;
      al_md        <= al_md_nxt;
      al_hu        <= al_hu_nxt;
      al_hd        <= al_hd_nxt;
      snooze_cnt   <= snooze_nxt;
      ring_cnt     <= ring_nxt;
      armed_q      <= (state_nxt != DISARMED);
      ringing_q    <= (state_nxt == RINGING);

      if (minute_ev)
        settle_cnt <= 4'(SETTLE);
      else if (settle_cnt != 4'd0)
        settle_cnt <= settle_cnt - 4'd1;

      if (state_nxt == RINGING) begin
        if (state != RINGING) begin
          div_cnt  <= 16'd0;
          buzzer_q <= 1'b0;
        end else if (div_cnt == 16'(BUZZ_DIV - 1)) begin
          div_cnt  <= 16'd0;
          buzzer_q <= ~buzzer_q;
        end else begin
          div_cnt <= div_cnt + 16'd1;
        end
      end else begin
        div_cnt  <= 16'd0;
        buzzer_q <= 1'b0;
      end
    end
  end

  assign bus.al_min_u = al_mu;
  assign bus.al_min_d = al_md;
  assign bus.al_hrs_u = al_hu;
  assign bus.al_hrs_d = al_hd;
  assign bus.armed    = armed_q;
  assign bus.ringing  = ringing_q;
  assign bus.buzzer   = buzzer_q;

endmodule

// File: tb/tb_alarm_unit.sv
// Scoreboard bench for alarm_unit: each stimulus step pushes the expected
// outputs for the following cycle; the sample after the clock edge pops and
// compares them.
module tb_alarm_unit;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alarm_unit_if bus ();

  alarm_unit #(
    .FRECUENCY (32768),
    .BUZZ_DIV  (16),
    .SETTLE    (4),
    .SNOOZE_MIN(5),
    .RING_MIN  (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic        armed;
    logic        ringing;
    logic        buzzer;
    logic        buz_care;
    logic [15:0] al;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   al_h     = 0;
  int   al_m     = 0;
  logic exp_armed = 1'b0;

  function automatic logic [15:0] bcd4(input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_next(input string tag, input logic a, input logic r,
                             input logic b, input logic bc);
    exp_t e;
    sb_q.push_back({a, r, b, bc, bcd4(al_h, al_m)});
    tick();
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, observed armed=%b expected entry", tag, bus.armed);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".armed"},   {15'd0, bus.armed},   {15'd0, e.armed});
      check({tag, ".ringing"}, {15'd0, bus.ringing}, {15'd0, e.ringing});
      if (e.buz_care)
        check({tag, ".buzzer"}, {15'd0, bus.buzzer}, {15'd0, e.buzzer});
      check({tag, ".alarm"},
            {bus.al_hrs_d, bus.al_hrs_u, bus.al_min_d, bus.al_min_u}, e.al);
    end
  endtask

  task automatic set_time(input int h, input int m);
    bus.hrs_d = 4'(h / 10);
    bus.hrs_u = 4'(h % 10);
    bus.min_d = 4'(m / 10);
    bus.min_u = 4'(m % 10);
  endtask

  task automatic flip();
    bus.minute_toggle = ~bus.minute_toggle;
  endtask

  task automatic press_hrs();
    bus.btn_set_hrs = 1'b1;
    al_h = (al_h + 1) % 24;
    expect_next("set_hrs", exp_armed, 1'b0, 1'b0, 1'b1);
    bus.btn_set_hrs = 1'b0;
    tick();
  endtask

  task automatic press_min();
    bus.btn_set_min = 1'b1;
    al_m = (al_m + 1) % 60;
    expect_next("set_min", exp_armed, 1'b0, 1'b0, 1'b1);
    bus.btn_set_min = 1'b0;
    tick();
  endtask

  task automatic press_mode(input string tag);
    bus.btn_mode = 1'b1;
    exp_armed = ~exp_armed;
    expect_next(tag, exp_armed, 1'b0, 1'b0, 1'b1);
    bus.btn_mode = 1'b0;
    tick();
  endtask

  // From ARMED with alarm 07:00: a non-matching minute, then a matching one.
  task automatic ring_up();
    set_time(6, 59);
    flip();
    repeat (6) expect_next("pre_match", 1'b1, 1'b0, 1'b0, 1'b1);
    set_time(7, 0);
    flip();
    repeat (4) expect_next("settle", 1'b1, 1'b0, 1'b0, 1'b1);
    expect_next("ring_rise", 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    bus.minute_toggle = 1'b0;
    bus.btn_set_min = 1'b0;
    bus.btn_set_hrs = 1'b0;
    bus.btn_mode    = 1'b0;
    bus.btn_snooze  = 1'b0;
    set_time(0, 0);
    repeat (3) tick();
    reset = 1'b0;
    expect_next("reset", 1'b0, 1'b0, 1'b0, 1'b1);

    // Alarm digit wrap
    repeat (23) press_hrs();
    expect_next("hrs_23", 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (59) press_min();
    expect_next("min_59", 1'b0, 1'b0, 1'b0, 1'b1);
    press_min();
    expect_next("min_wrap", 1'b0, 1'b0, 1'b0, 1'b1);
    press_hrs();
    expect_next("hrs_wrap", 1'b0, 1'b0, 1'b0, 1'b1);

    bus.btn_set_min = 1'b1;
    bus.btn_set_hrs = 1'b1;
    al_h = 1;
    al_m = 1;
    expect_next("set_both", 1'b0, 1'b0, 1'b0, 1'b1);
    bus.btn_set_min = 1'b0;
    bus.btn_set_hrs = 1'b0;
    tick();

    // Alarm to 07:00
    repeat (6) press_hrs();
    repeat (59) press_min();
    expect_next("alarm_0700", 1'b0, 1'b0, 1'b0, 1'b1);

    // Match and stop
    set_time(6, 59);
    press_mode("arm");
    set_time(7, 0);
    flip();
    repeat (4) expect_next("match_settle", 1'b1, 1'b0, 1'b0, 1'b1);
    expect_next("match_ring", 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 40; i++)
      expect_next("buzz", 1'b1, 1'b1, 1'((i / 16) % 2), 1'b1);
    bus.btn_mode = 1'b1;
    expect_next("stop", 1'b1, 1'b0, 1'b0, 1'b1);
    bus.btn_mode = 1'b0;
    tick();

    // Snooze
    ring_up();
    bus.btn_snooze = 1'b1;
    expect_next("snooze", 1'b1, 1'b0, 1'b0, 1'b1);
    bus.btn_snooze = 1'b0;
    tick();
    for (int k = 1; k <= 4; k++) begin
      set_time(7, k);
      flip();
      expect_next("snoozed", 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
    end
    set_time(7, 5);
    flip();
    expect_next("snooze_expire", 1'b1, 1'b1, 1'b0, 1'b1);

    // Set buttons ignored while ringing
    bus.btn_set_min = 1'b1;
    bus.btn_set_hrs = 1'b1;
    expect_next("set_in_ring", 1'b1, 1'b1, 1'b0, 1'b0);
    bus.btn_set_min = 1'b0;
    bus.btn_set_hrs = 1'b0;
    expect_next("set_in_ring2", 1'b1, 1'b1, 1'b0, 1'b0);

    // Timeout after three minute events
    flip();
    expect_next("timeout_1", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    flip();
    expect_next("timeout_2", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    flip();
    expect_next("timeout_3", 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (6) expect_next("after_timeout", 1'b1, 1'b0, 1'b0, 1'b1);

    // Armed but time mismatched
    set_time(7, 1);
    flip();
    repeat (8) expect_next("mismatch", 1'b1, 1'b0, 1'b0, 1'b1);

    // Disarmed with matching time
    press_mode("disarm");
    set_time(7, 0);
    flip();
    repeat (8) expect_next("disarmed_match", 1'b0, 1'b0, 1'b0, 1'b1);

    // Mode beats snooze in the same cycle
    press_mode("rearm");
    ring_up();
    bus.btn_mode   = 1'b1;
    bus.btn_snooze = 1'b1;
    expect_next("prio", 1'b1, 1'b0, 1'b0, 1'b1);
    bus.btn_mode   = 1'b0;
    bus.btn_snooze = 1'b0;
    tick();
    press_mode("prio_was_armed");

    // Reset mid-ringing with mode held high
    press_mode("rearm2");
    ring_up();
    reset = 1'b1;
    bus.btn_mode = 1'b1;
    al_h = 0;
    al_m = 0;
    exp_armed = 1'b0;
    expect_next("rst_ring", 1'b0, 1'b0, 1'b0, 1'b1);
    expect_next("rst_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    repeat (4) expect_next("rst_no_arm", 1'b0, 1'b0, 1'b0, 1'b1);
    bus.btn_mode = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
